// File: rtl/dreamshp_loader_pkg.sv
// Shared definitions for the Dream Shopper ROM loader.
// Contents:
//   - the download address map (region bases and the end of the image);
//   - the region index and loader state enums;
//   - default image size, settle length and counter width;
//   - a helper that turns a region index into its one-hot write strobe.
package dreamshp_loader_pkg;

  // Absolute download addresses. Each region ends where the next one begins.
  localparam logic [24:0] CPU_BASE  = 25'h000_0000;
  localparam logic [24:0] GFX_BASE  = 25'h000_8000;
  localparam logic [24:0] COL_BASE  = 25'h000_A000;
  localparam logic [24:0] LUT_BASE  = 25'h000_A020;
  localparam logic [24:0] SND_BASE  = 25'h000_A120;
  localparam logic [24:0] IMG_LIMIT = 25'h000_A220;

  localparam int          NUM_REGIONS           = 5;
  localparam logic [16:0] EXPECTED_SIZE_DEFAULT = 17'd41504;
  localparam int          HOLD_CYCLES_DEFAULT   = 16;
  localparam int          CNT_W_DEFAULT         = 17;

  typedef enum logic [2:0] {
    REG_CPU = 3'd0,
    REG_GFX = 3'd1,
    REG_COL = 3'd2,
    REG_LUT = 3'd3,
    REG_SND = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  function automatic logic [NUM_REGIONS-1:0] region_onehot(region_e r);
    return NUM_REGIONS'(1) << r;
  endfunction

endpackage

// File: rtl/dreamshp_region_decode.sv
// Combinational decoder from an absolute download address to a ROM region.
// Ports:
//   dn_addr   in  25  absolute byte address from the download stream
//   valid     out 1   address falls inside the image (below 0xA220)
//   region_oh out 5   one-hot region strobe, all zero when not valid
//   rel_addr  out 16  address relative to the region base, zero when not valid
module dreamshp_region_decode
  import dreamshp_loader_pkg::*;
(
  input  logic [24:0]            dn_addr,
  output logic                   valid,
  output logic [NUM_REGIONS-1:0] region_oh,
  output logic [15:0]            rel_addr
);

  region_e     region;
  logic [15:0] base;

  // Full 25-bit compares so that any set bit in 24:16 lands in the
  // out-of-range branch rather than aliasing into a low region.
  always_comb begin
    valid     = 1'b1;
    region    = REG_CPU;
    base      = CPU_BASE[15:0];
    region_oh = '0;
    rel_addr  = '0;
    if (dn_addr < GFX_BASE) begin
      region = REG_CPU;
      base   = CPU_BASE[15:0];
    end else if (dn_addr < COL_BASE) begin
      region = REG_GFX;
      base   = GFX_BASE[15:0];
    end else if (dn_addr < LUT_BASE) begin
      region = REG_COL;
      base   = COL_BASE[15:0];
    end else if (dn_addr < SND_BASE) begin
      region = REG_LUT;
      base   = LUT_BASE[15:0];
    end else if (dn_addr < IMG_LIMIT) begin
      region = REG_SND;
      base   = SND_BASE[15:0];
    end else begin
      valid = 1'b0;
    end
    if (valid) begin
      region_oh = region_onehot(region);
      rel_addr  = dn_addr[15:0] - base;
    end
  end

endmodule

// File: rtl/dreamshp_rom_loader.sv
// Sequences the HPS ROM download stream into the Dream Shopper ROM/PROM
// regions, validates the image size and holds the core in reset until a
// valid image has loaded and a short settle window has passed.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   dn_download         download in progress (level)
//   dn_wr               one-cycle byte strobe, honoured only while downloading
//   dn_addr, dn_data    absolute byte address and data
//   rom_addr, rom_data  registered region-relative address and data
//   rom_we              registered one-hot region write enable
//   core_reset          registered reset to the core
//   load_done, load_err sticky image verdicts, cleared when a download starts
//   byte_count          accepted in-range writes in the current/last download
module dreamshp_rom_loader
  import dreamshp_loader_pkg::*;
#(
  parameter int               CNT_W         = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] EXPECTED_SIZE = CNT_W'(EXPECTED_SIZE_DEFAULT),
  parameter int               HOLD_CYCLES   = HOLD_CYCLES_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   dn_download,
  input  logic                   dn_wr,
  input  logic [24:0]            dn_addr,
  input  logic [7:0]             dn_data,
  output logic [15:0]            rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_err,
  output logic [CNT_W-1:0]       byte_count
);

  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [CNT_W-1:0]         byte_count_q, byte_count_d;
  logic                     load_done_q, load_done_d;
  logic                     load_err_q, load_err_d;
  logic                     range_err_q, range_err_d;
  logic                     core_reset_q, core_reset_d;
  logic [NUM_REGIONS-1:0]   rom_we_q, rom_we_d;
  logic [15:0]              rom_addr_q, rom_addr_d;
  logic [7:0]               rom_data_q, rom_data_d;

  logic                     addr_valid;
  logic [NUM_REGIONS-1:0]   addr_region_oh;
  logic [15:0]              addr_rel;
  logic                     wr_ok;

  dreamshp_region_decode u_decode (
    .dn_addr   (dn_addr),
    .valid     (addr_valid),
    .region_oh (addr_region_oh),
    .rel_addr  (addr_rel)
  );

  // A strobe outside a download is meaningless; any download level forces
  // the FSM into LOAD this cycle, so an accepted write always counts there.
  assign wr_ok = dn_download & dn_wr;

  // Next-state, counters and write path. Entry clears are applied after the
  // state decision so a write arriving on the rising download edge is
  // counted on top of the cleared count rather than lost.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    byte_count_d = byte_count_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    range_err_d  = range_err_q;
    rom_we_d     = '0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;

    case (state_q)
      ST_IDLE: begin
        if (dn_download) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!dn_download) begin
          state_d = ST_SETTLE;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_SETTLE: begin
        if (dn_download) begin
          state_d = ST_LOAD;
        end else if (hold_q == '0) begin
          if ((byte_count_q == EXPECTED_SIZE) && !range_err_q) begin
            load_done_d = 1'b1;
            state_d     = ST_RUN;
          end else begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (dn_download) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      byte_count_d = '0;
      load_done_d  = 1'b0;
      load_err_d   = 1'b0;
      range_err_d  = 1'b0;
    end

    if (wr_ok) begin
      if (addr_valid) begin
        rom_we_d   = addr_region_oh;
        rom_addr_d = addr_rel;
        rom_data_d = dn_data;
        if (byte_count_d != '1) byte_count_d = byte_count_d + CNT_W'(1);
      end else begin
        range_err_d = 1'b1;
      end
    end

    core_reset_d = (state_d != ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      byte_count_q <= '0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      range_err_q  <= 1'b0;
      core_reset_q <= 1'b1;
      rom_we_q     <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      byte_count_q <= byte_count_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      range_err_q  <= range_err_d;
      core_reset_q <= core_reset_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_dreamshp_rom_loader.sv
// Directed bench for dreamshp_rom_loader. The DUT is built with a 48-byte
// image size so that every scenario fits in a few thousand cycles; the image
// places bytes on every region boundary and fills the rest in CPU ROM.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dreamshp_rom_loader;
  import dreamshp_loader_pkg::*;

  localparam int          IMG_BYTES = 48;
  localparam logic [16:0] TB_SIZE   = 17'd48;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        dn_download;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [4:0]  rom_we;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [16:0] byte_count;

  int checks = 0;
  int errors = 0;

  dreamshp_rom_loader #(.EXPECTED_SIZE(TB_SIZE)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_we      (rom_we),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_err    (load_err),
    .byte_count  (byte_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Image layout: first ten bytes hit every region's first and last address.
  function automatic logic [24:0] img_addr(int i);
    case (i)
      0: return 25'h0000;
      1: return 25'h7FFF;
      2: return 25'h8000;
      3: return 25'h9FFF;
      4: return 25'hA000;
      5: return 25'hA01F;
      6: return 25'hA020;
      7: return 25'hA11F;
      8: return 25'hA120;
      9: return 25'hA21F;
      default: return 25'h0100 + 25'(i);
    endcase
  endfunction

  function automatic logic [7:0] img_data(int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  // Reference region map written as a table walk.
  function automatic int ref_region(logic [24:0] a);
    logic [24:0] lo [5];
    logic [24:0] hi [5];
    lo = '{25'h0000, 25'h8000, 25'hA000, 25'hA020, 25'hA120};
    hi = '{25'h7FFF, 25'h9FFF, 25'hA01F, 25'hA11F, 25'hA21F};
    for (int r = 0; r < 5; r++)
      if (a >= lo[r] && a <= hi[r]) return r;
    return -1;
  endfunction

  function automatic logic [4:0] ref_we(logic [24:0] a);
    int r;
    r = ref_region(a);
    if (r < 0) return 5'b0;
    return 5'b00001 << r;
  endfunction

  function automatic logic [15:0] ref_rel(logic [24:0] a);
    logic [24:0] lo [5];
    int r;
    lo = '{25'h0000, 25'h8000, 25'hA000, 25'hA020, 25'hA120};
    r = ref_region(a);
    if (r < 0) return 16'h0;
    return 16'(a - lo[r]);
  endfunction

  // One strobe: high for one cycle, returns on the cycle its result is visible.
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge CLK);
    dn_wr   = 1'b1;
    dn_addr = a;
    dn_data = d;
    @(negedge CLK);
    dn_wr = 1'b0;
  endtask

  task automatic start_download();
    @(negedge CLK);
    dn_download = 1'b1;
  endtask

  task automatic end_download();
    @(negedge CLK);
    dn_download = 1'b0;
  endtask

  task automatic run_full_load();
    start_download();
    for (int i = 0; i < IMG_BYTES; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    end_download();
    repeat (17) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    repeat (3) @(negedge CLK);
    checks++; if (rom_we !== 5'b0) begin errors++; $display("[TB] FAIL reset_rom_we: got %b expected 00000", rom_we); end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %h expected 0000", rom_addr); end
    checks++; if (rom_data !== 8'h0) begin errors++; $display("[TB] FAIL reset_rom_data: got %h expected 00", rom_data); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b expected 0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err: got %b expected 0", load_err); end
    checks++; if (byte_count !== 17'd0) begin errors++; $display("[TB] FAIL reset_byte_count: got %0d expected 0", byte_count); end
    RESET = 1'b0;
  endtask

  task automatic test_power_up_idle();
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      checks++;
      if (core_reset !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || rom_we !== 5'b0) begin
        errors++;
        $display("[TB] FAIL idle_cycle_%0d: got core_reset=%b done=%b err=%b we=%b expected 1 0 0 00000",
                 c, core_reset, load_done, load_err, rom_we);
      end
    end
  endtask

  task automatic test_full_image();
    logic [24:0] a;
    start_download();
    for (int i = 0; i < IMG_BYTES; i++) begin
      a = img_addr(i);
      write_byte(a, img_data(i));
      checks++;
      if (rom_we !== ref_we(a) || rom_addr !== ref_rel(a) || rom_data !== img_data(i)) begin
        errors++;
        $display("[TB] FAIL write_%0d addr %h: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                 i, a, rom_we, rom_addr, rom_data, ref_we(a), ref_rel(a), img_data(i));
      end
      if (a == 25'h8000) begin
        checks++;
        if (rom_we !== 5'b00010 || rom_addr !== 16'h0000) begin
          errors++; $display("[TB] FAIL gfx_base: got we=%b addr=%h expected 00010 0000", rom_we, rom_addr);
        end
      end
      if (a == 25'hA120) begin
        checks++;
        if (rom_we !== 5'b10000 || rom_addr !== 16'h0000) begin
          errors++; $display("[TB] FAIL snd_base: got we=%b addr=%h expected 10000 0000", rom_we, rom_addr);
        end
      end
      checks++;
      if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL load_core_reset_%0d: got %b expected 1", i, core_reset); end
      @(negedge CLK);
      checks++;
      if (rom_we !== 5'b0) begin errors++; $display("[TB] FAIL we_single_cycle_%0d: got %b expected 00000", i, rom_we); end
    end
    end_download();
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      checks++;
      if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL settle_hold_%0d: got core_reset=%b expected 1", k, core_reset); end
    end
    @(negedge CLK);
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL release_core_reset: got %b expected 0", core_reset); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL full_load_done: got %b expected 1", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL full_load_err: got %b expected 0", load_err); end
    checks++; if (byte_count !== 17'd48) begin errors++; $display("[TB] FAIL full_byte_count: got %0d expected 48", byte_count); end
  endtask

  task automatic test_truncated();
    start_download();
    @(negedge CLK);
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL trunc_enter_reset: got %b expected 1", core_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL trunc_enter_done: got %b expected 0", load_done); end
    for (int i = 0; i < IMG_BYTES - 1; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    end_download();
    @(negedge CLK);
    checks++; if (byte_count !== 17'd47) begin errors++; $display("[TB] FAIL trunc_byte_count: got %0d expected 47", byte_count); end
    repeat (16) @(negedge CLK);
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL trunc_load_err: got %b expected 1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL trunc_load_done: got %b expected 0", load_done); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL trunc_core_reset: got %b expected 1", core_reset); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("[TB] FAIL trunc_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_out_of_range();
    start_download();
    for (int i = 0; i < IMG_BYTES; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    write_byte(25'hA220, 8'h77);
    checks++; if (rom_we !== 5'b0) begin errors++; $display("[TB] FAIL oor_a220_we: got %b expected 00000", rom_we); end
    checks++; if (byte_count !== 17'd48) begin errors++; $display("[TB] FAIL oor_a220_count: got %0d expected 48", byte_count); end
    @(negedge CLK);
    write_byte(25'h001_0010, 8'h88);
    checks++; if (rom_we !== 5'b0) begin errors++; $display("[TB] FAIL oor_high_we: got %b expected 00000", rom_we); end
    checks++; if (byte_count !== 17'd48) begin errors++; $display("[TB] FAIL oor_high_count: got %0d expected 48", byte_count); end
    @(negedge CLK);
    end_download();
    repeat (17) @(negedge CLK);
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_load_err: got %b expected 1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL oor_load_done: got %b expected 0", load_done); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL oor_core_reset: got %b expected 1", core_reset); end
  endtask

  task automatic test_reload_from_run();
    run_full_load();
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL reload_pre_run: got core_reset=%b expected 0", core_reset); end
    // Download rises in the same cycle as the first strobe.
    @(negedge CLK);
    dn_download = 1'b1; dn_wr = 1'b1; dn_addr = 25'h0000; dn_data = 8'h3C;
    @(negedge CLK);
    dn_wr = 1'b0;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reload_core_reset: got %b expected 1", core_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reload_done_clear: got %b expected 0", load_done); end
    checks++; if (byte_count !== 17'd1) begin errors++; $display("[TB] FAIL reload_first_count: got %0d expected 1", byte_count); end
    checks++; if (rom_we !== 5'b00001 || rom_data !== 8'h3C) begin
      errors++; $display("[TB] FAIL reload_first_write: got we=%b data=%h expected 00001 3c", rom_we, rom_data);
    end
    for (int i = 1; i < IMG_BYTES; i++) begin
      @(negedge CLK);
      write_byte(img_addr(i), img_data(i));
    end
    end_download();
    repeat (17) @(negedge CLK);
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL reload_done: got %b expected 1", load_done); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL reload_run: got core_reset=%b expected 0", core_reset); end
    checks++; if (byte_count !== 17'd48) begin errors++; $display("[TB] FAIL reload_count: got %0d expected 48", byte_count); end
  endtask

  task automatic test_settle_abort();
    start_download();
    for (int i = 0; i < IMG_BYTES; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    end_download();
    repeat (6) @(negedge CLK);
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_settle: got core_reset=%b expected 1", core_reset); end
    dn_download = 1'b1;
    @(negedge CLK);
    checks++; if (dut.state_q !== ST_LOAD) begin errors++; $display("[TB] FAIL abort_state: got %0d expected %0d", dut.state_q, ST_LOAD); end
    checks++; if (byte_count !== 17'd0) begin errors++; $display("[TB] FAIL abort_count: got %0d expected 0", byte_count); end
    repeat (20) @(negedge CLK);
    checks++; if (load_done !== 1'b0 || core_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_no_eval: got done=%b core_reset=%b expected 0 1", load_done, core_reset);
    end
    for (int i = 0; i < IMG_BYTES; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    end_download();
    repeat (17) @(negedge CLK);
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_done: got %b expected 1", load_done); end
  endtask

  task automatic test_reset_midload();
    start_download();
    for (int i = 0; i < 20; i++) begin
      write_byte(img_addr(i), img_data(i));
      @(negedge CLK);
    end
    @(negedge CLK);
    RESET = 1'b1; dn_download = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if (rom_we !== 5'b0 || rom_addr !== 16'h0 || rom_data !== 8'h0) begin
      errors++; $display("[TB] FAIL midreset_rom: got we=%b addr=%h data=%h expected 00000 0000 00", rom_we, rom_addr, rom_data);
    end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL midreset_core_reset: got %b expected 1", core_reset); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flags: got done=%b err=%b expected 0 0", load_done, load_err);
    end
    checks++; if (byte_count !== 17'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", byte_count); end
    run_full_load();
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reload_done: got %b expected 1", load_done); end
    checks++; if (byte_count !== 17'd48) begin errors++; $display("[TB] FAIL midreset_reload_count: got %0d expected 48", byte_count); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL midreset_reload_run: got %b expected 0", core_reset); end
  endtask

  initial begin
    test_reset();
    test_power_up_idle();
    test_full_image();
    test_truncated();
    test_out_of_range();
    test_reload_from_run();
    test_settle_abort();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dreamshp_rom_loader.md
Name: dreamshp_rom_loader

Overview:
Sequences the HPS ROM download stream into the Dream Shopper core's ROM/PROM regions.
- Decodes each download byte into one of five region write strobes.
- Counts and validates the image.
- Holds the core in reset from power-up through download and a settle window, then releases it.
- Sits between hps_io's ioctl bus and the dreamshp core's dn_* inputs and RESET.

Parameters:
- EXPECTED_SIZE, 17'd41504, exact byte count of a valid image (0x0000–0xA21F).
- HOLD_CYCLES, 16, CLK cycles core_reset stays high after a download ends.
- CNT_W, 17, width of byte_count.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- dn_download  input  1  download in progress (level).
- dn_wr  input  1  one-cycle byte write strobe, valid only while dn_download=1.
- dn_addr  input  25  byte address of dn_data.
- dn_data  input  8  download byte.
- rom_addr  output  16  region-relative address, registered.
- rom_data  output  8  registered copy of dn_data.
- rom_we  output  5  one-hot region write enable: [0] CPU ROM, [1] GFX ROM, [2] colour PROM, [3] lookup PROM, [4] sound PROM.
- core_reset  output  1  reset to the core.
- load_done  output  1  a valid image has been loaded; sticky until the next download starts.
- load_err  output  1  the last download was invalid; sticky until the next download starts.
- byte_count  output  17  number of accepted in-range writes in the current or last download.

Behaviour:
- Reset values: state=IDLE, rom_we=0, rom_addr=0, rom_data=0, core_reset=1, load_done=0, load_err=0, byte_count=0, hold counter=0.
- Region map (absolute dn_addr, base subtracted for rom_addr):
  - CPU ROM 0x0000–0x7FFF
  - GFX ROM 0x8000–0x9FFF
  - colour PROM 0xA000–0xA01F
  - lookup PROM 0xA020–0xA11F
  - sound PROM 0xA120–0xA21F
- Write latency: 1 cycle. dn_wr at cycle N produces rom_we/rom_addr/rom_data at N+1. rom_we is high for exactly one cycle per accepted write and is never multi-hot.
- Out-of-range write (dn_addr ≥ 0xA220, including any of bits 24:16 set):
  - rom_we stays 0 and byte_count does not increment.
  - An internal range-error flag is set for the current download.
- dn_wr with dn_download=0 is ignored in every state.
- byte_count saturates at 2^CNT_W−1; it never wraps.
- State machine:
  - IDLE: core_reset=1. Moves to LOAD when dn_download=1.
  - LOAD: core_reset=1 and writes are accepted. On entry, byte_count, load_done, load_err and the range-error flag clear. When dn_download=0, moves to SETTLE and loads the hold counter with HOLD_CYCLES−1.
  - SETTLE: core_reset=1 and the counter decrements each cycle. At 0, evaluates the image:
    - Valid (byte_count==EXPECTED_SIZE and no range error): load_done=1, go to RUN.
    - Otherwise: load_err=1, go to IDLE, and core_reset stays 1.
  - RUN: core_reset=0. dn_download=1 returns to LOAD; core_reset goes 1 in the same registered cycle as the LOAD entry.
- Boundaries:
  - dn_download rising in SETTLE returns to LOAD immediately and aborts evaluation.
  - Download rising and dn_wr in the same cycle: the write is accepted and counted in the new LOAD.
  - A download ending in the same cycle as a dn_wr: the write is still processed.
  - Duplicate addresses count every write, so a duplicated image fails the size check.
  - RESET mid-LOAD: immediate return to the reset values. The partially written ROMs are not cleared and the core stays in reset until a full valid load.
- core_reset is registered (glitch-free). The top level ORs it with its own user reset sources.

Decomposition:
- Package dreamshp_loader_pkg holds:
  - region base/limit localparams;
  - region index enum (REG_CPU, REG_GFX, REG_COL, REG_LUT, REG_SND);
  - state enum (ST_IDLE, ST_LOAD, ST_SETTLE, ST_RUN);
  - EXPECTED_SIZE default.
- One sub-module, dreamshp_region_decode: combinational dn_addr → {valid, region one-hot, rel_addr}. It is unit-testable on its own. The sequencing, counters and registers stay in the top module.

Test Plan:
- Power-up, no download for 1000 cycles → core_reset=1, load_done=0, load_err=0, rom_we=0 throughout.
- Full 41504-byte image written sequentially, dn_wr every 3rd cycle:
  - addr 0x8000 gives rom_we=5'b00010, rom_addr=0x0000 one cycle later;
  - addr 0xA120 gives rom_we=5'b10000, rom_addr=0;
  - after download falls, core_reset falls exactly 16 cycles later and load_done=1.
- Image truncated at 41503 bytes → byte_count=41503; after 16 cycles load_err=1, state IDLE, core_reset stays 1.
- Valid image plus one byte at 0xA220 → no rom_we for that byte, byte_count=41504, load_err=1 at settle end.
- RUN, then a second download starts → core_reset=1 the cycle after dn_download rises; load_done clears; a valid reload returns to RUN.
- RESET pulsed at byte 20000 of a load, then a full valid load → all outputs return to reset values; the next full load ends with load_done=1 and byte_count=41504.
